irq_sequencer: RTL and testbench

Interrupt controller and pipeline sequencer for the RISC-V processor core. It captures rising edges on external interrupt lines and selects the highest-priority enabled request. It then drives the fetch/pipeline control: stall, drain, flush, save the resume PC, and redirect to a per-source vector. It sits beside the hazard unit and feeds the PC-select mux, the pipeline stall/flush nets (`pipeline_stall_dbg` and `pipeline_flush_dbg` are ORed from its outputs), and `mret` return handling.

---
 rtl/irq_pkg.sv | 25 ++
 rtl/irq_priority_enc.sv | 28 ++
 rtl/irq_sequencer.sv | 153 +++++++++++++++
 tb/tb_irq_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// ----------------------------------------------------------------------------
// irq_pkg
// Types and constants shared by the interrupt sequencer and its priority
// encoder.
//   irq_state_e    : sequencer FSM states
//   CAUSE_W        : width of the cause (source ID) output
//   VEC_BASE_DEF   : default vector table base address
//   DRAIN_MAX_DEF  : default drain time-out, in cycles
// ----------------------------------------------------------------------------
package irq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_FLUSH,
      ST_VECTOR,
      ST_HANDLER,
      ST_RETURN
   } irq_state_e;

   localparam int          CAUSE_W       = 5;
   localparam logic [31:0] VEC_BASE_DEF  = 32'h0000_0100;
   localparam int          DRAIN_MAX_DEF = 16;

endpackage : irq_pkg

// File: rtl/irq_priority_enc.sv
// ----------------------------------------------------------------------------
// irq_priority_enc
// Fixed-priority encoder: the lowest set index of req_i wins.
//   req_i   in  N     request vector
//   valid_o out 1     at least one request present
//   id_o    out ID_W  index of the winning request (0 when none)
// ----------------------------------------------------------------------------
module irq_priority_enc #(
   parameter int N    = 8,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req_i,
   output logic            valid_o,
   output logic [ID_W-1:0] id_o
);

   // Scan from the top down so the lowest set index is the last to assign.
   always_comb begin
      valid_o = |req_i;
      id_o    = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            id_o = ID_W'(i);
         end
      end
   end

endmodule : irq_priority_enc

// File: rtl/irq_sequencer.sv
// ----------------------------------------------------------------------------
// irq_sequencer
// Captures rising edges on the interrupt lines, picks the lowest-index
// enabled request and sequences the pipeline into the handler:
// stall/drain, flush (saving the resume PC), redirect to the vector, then
// redirect back to the saved PC when MRET retires.
//   clk, reset_n        clock, asynchronous active-low reset
//   irq_i               interrupt lines (rising edge = request)
//   irq_en_i            per-source enable mask
//   global_ie_i         global interrupt enable
//   commit_pc_i         PC of the oldest un-retired instruction
//   pipe_idle_i         pipeline has drained
//   mret_i              MRET retired (one-cycle pulse)
//   stall_o, flush_o    pipeline control
//   redirect_valid_o    load redirect_pc_o into the PC this cycle
//   redirect_pc_o       vector address or saved PC (0 when not redirecting)
//   epc_o, cause_o      saved resume PC and taken source ID
//   in_handler_o        handler active
//   pending_o           captured, not yet taken requests
// All outputs are decoded from registered state only.
// ----------------------------------------------------------------------------
module irq_sequencer
   import irq_pkg::*;
#(
   parameter int          NUM_IRQ   = 8,
   parameter logic [31:0] VEC_BASE  = VEC_BASE_DEF,
   parameter int          DRAIN_MAX = DRAIN_MAX_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic [NUM_IRQ-1:0] irq_en_i,
   input  logic               global_ie_i,
   input  logic [31:0]        commit_pc_i,
   input  logic               pipe_idle_i,
   input  logic               mret_i,
   output logic               stall_o,
   output logic               flush_o,
   output logic               redirect_valid_o,
   output logic [31:0]        redirect_pc_o,
   output logic [31:0]        epc_o,
   output logic [CAUSE_W-1:0] cause_o,
   output logic               in_handler_o,
   output logic [NUM_IRQ-1:0] pending_o
);

   localparam int ID_W  = $clog2(NUM_IRQ);
   localparam int CNT_W = $clog2(DRAIN_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX - 1);

   irq_state_e         state_q, state_d;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] irq_prev_q;
   logic [ID_W-1:0]    sel_id_q, sel_id_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        epc_q, epc_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;

   logic               req_valid;
   logic [ID_W-1:0]    req_id;

   irq_priority_enc #(
      .N    (NUM_IRQ),
      .ID_W (ID_W)
   ) u_prio (
      .req_i   (pending_q & irq_en_i),
      .valid_o (req_valid),
      .id_o    (req_id)
   );

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      sel_id_d  = sel_id_q;
      cnt_d     = cnt_q;
      epc_d     = epc_q;
      cause_d   = cause_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid && global_ie_i) begin
               state_d  = ST_DRAIN;
               sel_id_d = req_id;
               cnt_d    = '0;
            end
         end
         ST_DRAIN: begin
            cnt_d = cnt_q + 1'b1;
            // Time-out forces the flush even if the pipe never reports idle.
            if (pipe_idle_i || (cnt_q == CNT_LAST)) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            epc_d             = commit_pc_i;
            cause_d           = CAUSE_W'(sel_id_q);
            pending_d[sel_id_q] = 1'b0;
            state_d           = ST_VECTOR;
         end
         ST_VECTOR:  state_d = ST_HANDLER;
         ST_HANDLER: begin
            if (mret_i) begin
               state_d = ST_RETURN;
            end
         end
         ST_RETURN:  state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      // A new edge on the bit being taken overrides the clear.
      pending_d = pending_d | (irq_i & ~irq_prev_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         pending_q  <= '0;
         irq_prev_q <= '0;
         sel_id_q   <= '0;
         cnt_q      <= '0;
         epc_q      <= '0;
         cause_q    <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         irq_prev_q <= irq_i;
         sel_id_q   <= sel_id_d;
         cnt_q      <= cnt_d;
         epc_q      <= epc_d;
         cause_q    <= cause_d;
      end
   end

   always_comb begin
      stall_o          = (state_q == ST_DRAIN) || (state_q == ST_FLUSH);
      flush_o          = (state_q == ST_FLUSH);
      in_handler_o     = (state_q == ST_HANDLER);
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
      if (state_q == ST_VECTOR) begin
         redirect_valid_o = 1'b1;
         redirect_pc_o    = VEC_BASE + 32'({sel_id_q, 2'b00});
      end else if (state_q == ST_RETURN) begin
         redirect_valid_o = 1'b1;
         redirect_pc_o    = epc_q;
      end
   end

   assign epc_o     = epc_q;
   assign cause_o   = cause_q;
   assign pending_o = pending_q;

endmodule : irq_sequencer

// File: tb/tb_irq_sequencer.sv
// ----------------------------------------------------------------------------
// tb_irq_sequencer
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a behavioural model of the interrupt sequence.
// ----------------------------------------------------------------------------
module tb_irq_sequencer;

   localparam int          N  = 8;
   localparam logic [31:0] VB = 32'h0000_0100;
   localparam int          DM = 16;

   localparam int P_IDLE    = 0;
   localparam int P_DRAIN   = 1;
   localparam int P_FLUSH   = 2;
   localparam int P_VECTOR  = 3;
   localparam int P_HANDLER = 4;
   localparam int P_RETURN  = 5;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [N-1:0]  irq;
   logic [N-1:0]  en;
   logic          gie;
   logic [31:0]   pc;
   logic          idle;
   logic          mret;
   logic          stall_o;
   logic          flush_o;
   logic          redirect_valid_o;
   logic [31:0]   redirect_pc_o;
   logic [31:0]   epc_o;
   logic [4:0]    cause_o;
   logic          in_handler_o;
   logic [N-1:0]  pending_o;

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   int           m_phase;
   logic [N-1:0] m_pend;
   logic [N-1:0] m_prev;
   int           m_sel;
   int           m_drain;
   logic [31:0]  m_epc;
   int           m_cause;

   always #5 clk = ~clk;

   irq_sequencer #(
      .NUM_IRQ   (N),
      .VEC_BASE  (VB),
      .DRAIN_MAX (DM)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .irq_i            (irq),
      .irq_en_i         (en),
      .global_ie_i      (gie),
      .commit_pc_i      (pc),
      .pipe_idle_i      (idle),
      .mret_i           (mret),
      .stall_o          (stall_o),
      .flush_o          (flush_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o),
      .epc_o            (epc_o),
      .cause_o          (cause_o),
      .in_handler_o     (in_handler_o),
      .pending_o        (pending_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = P_IDLE;
      m_pend  = '0;
      m_prev  = '0;
      m_sel   = 0;
      m_drain = 0;
      m_epc   = '0;
      m_cause = 0;
   endtask

   // One clock edge of the interrupt sequence, using the inputs as sampled.
   task automatic model_step();
      logic [N-1:0] rise;
      logic [N-1:0] req;
      if (!reset_n) begin
         model_reset();
         return;
      end
      rise   = irq & ~m_prev;
      m_prev = irq;
      req    = m_pend & en;
      case (m_phase)
         P_IDLE: begin
            if (req != '0 && gie) begin
               for (int k = 0; k < N; k++) begin
                  if (req[k]) begin
                     m_sel = k;
                     break;
                  end
               end
               m_drain = 0;
               m_phase = P_DRAIN;
            end
         end
         P_DRAIN: begin
            m_drain = m_drain + 1;
            if (idle || m_drain == DM) m_phase = P_FLUSH;
         end
         P_FLUSH: begin
            m_epc          = pc;
            m_cause        = m_sel;
            m_pend[m_sel]  = 1'b0;
            m_phase        = P_VECTOR;
         end
         P_VECTOR:  m_phase = P_HANDLER;
         P_HANDLER: if (mret) m_phase = P_RETURN;
         default:   m_phase = P_IDLE;
      endcase
      m_pend = m_pend | rise;
   endtask

   task automatic compare_all();
      logic [31:0] exp_pc;
      exp_pc = '0;
      if (m_phase == P_VECTOR) exp_pc = VB + 32'(m_sel * 4);
      if (m_phase == P_RETURN) exp_pc = m_epc;
      check("stall",      stall_o, (m_phase == P_DRAIN || m_phase == P_FLUSH));
      check("flush",      flush_o, (m_phase == P_FLUSH));
      check("redir_vld",  redirect_valid_o, (m_phase == P_VECTOR || m_phase == P_RETURN));
      check("redir_pc",   redirect_pc_o, exp_pc);
      check("epc",        epc_o, m_epc);
      check("cause",      cause_o, 32'(m_cause));
      check("in_handler", in_handler_o, (m_phase == P_HANDLER));
      check("pending",    pending_o, m_pend);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic clear_irq();
      irq = '0;
      tick();
   endtask

   // Run until the handler is entered (bounded), then retire MRET and return.
   task automatic finish_seq();
      int k;
      k = 0;
      while (!in_handler_o && k < 60) begin
         tick();
         k++;
      end
      check("reach_handler", in_handler_o, 1);
      mret = 1'b1;
      tick();
      mret = 1'b0;
      tick();
   endtask

   initial begin
      int drain_len;
      int k;
      reset_n = 1'b0;
      irq     = '0;
      en      = '1;
      gie     = 1'b1;
      pc      = 32'h40;
      idle    = 1'b1;
      mret    = 1'b0;
      model_reset();
      #2;
      compare_all();
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // single source 3
      irq[3] = 1'b1;
      tick();
      check("t1_pending3", pending_o[3], 1);
      tick();
      check("t1_drain_stall", stall_o, 1);
      tick();
      check("t1_flush", flush_o, 1);
      tick();
      check("t1_vec_pc", redirect_pc_o, 32'h10C);
      check("t1_epc", epc_o, 32'h40);
      check("t1_cause", cause_o, 3);
      check("t1_pend3_clr", pending_o[3], 0);
      finish_seq();

      // simultaneous 5 and 2: 2 first, then 5
      clear_irq();
      irq[5] = 1'b1;
      irq[2] = 1'b1;
      tick();
      tick();
      tick();
      tick();
      check("t2_vec2", redirect_pc_o, 32'h108);
      tick();
      mret = 1'b1;
      tick();
      mret = 1'b0;
      check("t2_return_pc", redirect_pc_o, 32'h40);
      tick();
      tick();
      tick();
      tick();
      check("t2_vec5", redirect_pc_o, 32'h114);
      finish_seq();

      // drain time-out
      clear_irq();
      idle   = 1'b0;
      irq[0] = 1'b1;
      tick();
      drain_len = 0;
      k = 0;
      while (!flush_o && k < 40) begin
         tick();
         if (stall_o && !flush_o) drain_len++;
         k++;
      end
      check("t3_drain_len", drain_len, DM);
      check("t3_forced_flush", flush_o, 1);
      idle = 1'b1;
      finish_seq();

      // edge while in handler, return, then new drain; stray mret in idle
      clear_irq();
      irq[6] = 1'b1;
      k = 0;
      while (!in_handler_o && k < 20) begin
         tick();
         k++;
      end
      irq[1] = 1'b1;
      tick();
      check("t4_pend1", pending_o[1], 1);
      check("t4_no_redir", redirect_valid_o, 0);
      tick();
      mret = 1'b1;
      tick();
      mret = 1'b0;
      check("t4_ret_pc", redirect_pc_o, 32'h40);
      tick();
      check("t4_idle_gap", stall_o, 0);
      tick();
      check("t4_new_drain", stall_o, 1);
      finish_seq();
      tick();
      mret = 1'b1;
      tick();
      mret = 1'b0;
      check("t4_stray_mret", redirect_valid_o, 0);
      tick();
      check("t4_stray_hdl", in_handler_o, 0);

      // global disable then enable
      clear_irq();
      gie    = 1'b0;
      irq[4] = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("t5_gie_nostall", stall_o, 0);
      check("t5_gie_pend", pending_o[4], 1);
      gie = 1'b1;
      tick();
      check("t5_gie_drain", stall_o, 1);
      finish_seq();

      // per-source disable then enable
      clear_irq();
      en[7]  = 1'b0;
      irq[7] = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("t5_en_nostall", stall_o, 0);
      en[7] = 1'b1;
      tick();
      check("t5_en_drain", stall_o, 1);
      finish_seq();

      // asynchronous reset during drain
      clear_irq();
      idle   = 1'b0;
      irq[2] = 1'b1;
      tick();
      tick();
      check("t6_in_drain", stall_o, 1);
      reset_n = 1'b0;
      #1;
      model_reset();
      check("t6_rst_stall", stall_o, 0);
      check("t6_rst_pend", pending_o, 0);
      compare_all();
      irq = '0;
      tick();
      reset_n = 1'b1;
      idle    = 1'b1;
      tick();

      // a level held high is taken once only
      irq[2] = 1'b1;
      finish_seq();
      for (int i = 0; i < 5; i++) tick();
      check("t6_level_nostall", stall_o, 0);
      check("t6_level_nopend", pending_o[2], 0);

      // randomized traffic
      irq = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 15) == 0) irq[b] = ~irq[b];
         end
         if ($urandom_range(0, 199) == 0) begin
            if ($urandom_range(0, 1) == 0) en = N'($urandom);
            else en = '1;
         end
         gie  = ($urandom_range(0, 9) != 0);
         idle = ($urandom_range(0, 3) != 0);
         pc   = $urandom;
         mret = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 599) == 0) begin
            reset_n = 1'b0;
            #1;
            model_reset();
            compare_all();
            tick();
            reset_n = 1'b1;
         end
         tick();
      end
      mret = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_irq_sequencer
